// File: rtl/vga_fetch_out_if.sv
// VRAM fetch handshake between the pixel fetch stage and the CPU/video arbiter.
interface vga_fetch_out_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 8
);
  logic              vramReq;
  logic [ADDR_W-1:0] vramAddr;
  logic              vramAck;
  logic [DATA_W-1:0] vramData;

  modport master (output vramReq, output vramAddr, input vramAck, input vramData);
  modport slave  (input vramReq, input vramAddr, output vramAck, output vramData);
endinterface

// File: rtl/vga_fetch_out.sv
// VGA pixel fetch/shift stage: prefetches VRAM words into a small FIFO and
// serialises them MSB-first as BPP-bit pixels with optional horizontal doubling.
module vga_fetch_out #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned BPP        = 1,
  parameter int unsigned HSCALE     = 1,
  parameter int unsigned LINE_WORDS = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned H_TOTAL    = 800,
  parameter int unsigned V_TOTAL    = 525
) (
  input  logic              pixClock,
  input  logic              nReset,
  input  logic [9:0]        hCount,
  input  logic [9:0]        vCount,
  input  logic              hActive,
  input  logic              vActive,
  input  logic [ADDR_W-1:0] baseAddr,
  vga_fetch_out_if.master   vram,
  output logic [BPP-1:0]    pixOut,
  output logic              underrun,
  input  logic              clrUnderrun
);

  localparam int unsigned PPW    = DATA_W / BPP;
  localparam int unsigned PIX_W  = $clog2(PPW + 1);
  localparam int unsigned HOLD_W = (HSCALE > 1) ? $clog2(HSCALE) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned FC_W   = $clog2(LINE_WORDS + 1);

  typedef enum logic {IDLE, REQ} fetchState_e;

  fetchState_e       state, stateNext;
  logic              reqNext;
  logic [ADDR_W-1:0] addrNext;
  logic [ADDR_W-1:0] lineBase, lineBaseNext;
  logic [FC_W-1:0]   fetchCnt, fetchCntNext;
  logic              discard, discardNext;

  logic              lineEnd, frameEnd;
  logic              push, pop, load, lastHold, fifoEmpty;

  logic [DATA_W-1:0] fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr, rdPtr;
  logic [CNT_W-1:0]  fifoCount;
  logic [DATA_W-1:0] loadWord;

  logic [DATA_W-1:0] shiftReg;
  logic [PIX_W-1:0]  pixLeft;
  logic [HOLD_W-1:0] holdCnt;

  assign lineEnd   = (hCount == 10'(H_TOTAL - 1));
  assign frameEnd  = lineEnd && (vCount == 10'(V_TOTAL - 1));
  // Data acked for a request that straddled a flush is dropped.
  assign push      = (state == REQ) && vram.vramAck && !discard && !lineEnd;
  assign fifoEmpty = (fifoCount == '0);
  assign lastHold  = (pixLeft == PIX_W'(1)) && (holdCnt == HOLD_W'(HSCALE - 1));
  assign load      = hActive && !lineEnd && ((pixLeft == '0) || lastHold);
  assign pop       = load && !fifoEmpty;
  assign loadWord  = fifoEmpty ? '0 : fifoMem[rdPtr];

  // Fetch FSM state register.
  always_ff @(posedge pixClock or negedge nReset) begin
    if (!nReset) begin
      state         <= IDLE;
      vram.vramReq  <= 1'b0;
      vram.vramAddr <= '0;
      lineBase      <= '0;
      fetchCnt      <= '0;
      discard       <= 1'b0;
    end else begin
      state         <= stateNext;
      vram.vramReq  <= reqNext;
      vram.vramAddr <= addrNext;
      lineBase      <= lineBaseNext;
      fetchCnt      <= fetchCntNext;
      discard       <= discardNext;
    end
  end

  // Fetch FSM next state; line end and frame reload override the handshake.
  always_comb begin
    stateNext    = state;
    reqNext      = vram.vramReq;
    addrNext     = vram.vramAddr;
    lineBaseNext = lineBase;
    fetchCntNext = fetchCnt;
    discardNext  = discard;
    case (state)
      IDLE: begin
        if (!lineEnd && vActive && (fetchCnt < FC_W'(LINE_WORDS)) &&
            (fifoCount < CNT_W'(FIFO_DEPTH))) begin
          stateNext = REQ;
          reqNext   = 1'b1;
        end
      end
      REQ: begin
        if (vram.vramAck) begin
          stateNext   = IDLE;
          reqNext     = 1'b0;
          discardNext = 1'b0;
          if (push) begin
            addrNext     = vram.vramAddr + ADDR_W'(1);
            fetchCntNext = fetchCnt + FC_W'(1);
          end
        end
      end
    endcase
    if (frameEnd) begin
      lineBaseNext = baseAddr;
    end else if (lineEnd && vActive) begin
      lineBaseNext = lineBase + ADDR_W'(LINE_WORDS);
    end
    if (lineEnd) begin
      addrNext     = lineBaseNext;
      fetchCntNext = '0;
      if ((state == REQ) && !vram.vramAck) begin
        discardNext = 1'b1;
      end
    end
  end

  // Prefetch FIFO storage.
  always_ff @(posedge pixClock) begin
    if (push) begin
      fifoMem[wrPtr] <= vram.vramData;
    end
  end

  // Prefetch FIFO pointers; flushed at every line end.
  always_ff @(posedge pixClock or negedge nReset) begin
    if (!nReset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else if (lineEnd) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      if (push && !pop) begin
        fifoCount <= fifoCount + CNT_W'(1);
      end else if (pop && !push) begin
        fifoCount <= fifoCount - CNT_W'(1);
      end
    end
  end

  // Pixel shifter: a starved word slot is played out as zeros.
  always_ff @(posedge pixClock or negedge nReset) begin
    if (!nReset) begin
      shiftReg <= '0;
      pixLeft  <= '0;
      holdCnt  <= '0;
      pixOut   <= '0;
    end else if (lineEnd || !hActive) begin
      pixLeft  <= '0;
      holdCnt  <= '0;
      pixOut   <= '0;
    end else if (load) begin
      shiftReg <= loadWord;
      pixOut   <= loadWord[DATA_W-1 -: BPP];
      pixLeft  <= PIX_W'(PPW);
      holdCnt  <= '0;
    end else if (holdCnt == HOLD_W'(HSCALE - 1)) begin
      shiftReg <= shiftReg << BPP;
      pixOut   <= shiftReg[DATA_W-1-BPP -: BPP];
      pixLeft  <= pixLeft - PIX_W'(1);
      holdCnt  <= '0;
    end else begin
      holdCnt  <= holdCnt + HOLD_W'(1);
    end
  end

  // Sticky underrun; a new starvation event wins over a clear.
  always_ff @(posedge pixClock or negedge nReset) begin
    if (!nReset) begin
      underrun <= 1'b0;
    end else if (load && fifoEmpty) begin
      underrun <= 1'b1;
    end else if (clrUnderrun) begin
      underrun <= 1'b0;
    end
  end

  assert property (@(posedge pixClock) disable iff (!nReset)
                   !(push && (fifoCount == CNT_W'(FIFO_DEPTH))));

endmodule
